// File: rtl/nand_min.sv
// nand_min: 2:1 mux z = a&b | ~a&c built only from 2-input NAND cells,
// with optional registered outputs.
// Ports: clk, rst (async, active-high) | a, b, c in | w1 = ~(a&b), z out.
// REG_OUT=1: w1/z registered, 1-cycle latency, reset to w1=1 z=0.
// REG_OUT=0: w1/z combinational, clk/rst ignored.

module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    // The only logic primitive in this block; a 0 on either pin
    // forces y=1 even if the other pin is X.
    assign y = ~(a & b);
endmodule

module nand_min #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic w1,
    output logic z
);

    logic na;
    logic w1_c;
    logic w2;
    logic z_c;

    // Tying both inputs together makes the cell an inverter.
    nand2 u_na (.a(a),    .b(a),  .y(na));
    nand2 u_w1 (.a(a),    .b(b),  .y(w1_c));
    nand2 u_w2 (.a(na),   .b(c),  .y(w2));
    nand2 u_z  (.a(w1_c), .b(w2), .y(z_c));

    generate
        if (REG_OUT) begin : g_reg
            logic w1_q;
            logic z_q;

            // Reset value matches the abc=000 result.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w1_q <= 1'b1;
                    z_q  <= 1'b0;
                end else begin
                    w1_q <= w1_c;
                    z_q  <= z_c;
                end
            end

            assign w1 = w1_q;
            assign z  = z_q;
        end else begin : g_comb
            assign w1 = w1_c;
            assign z  = z_c;
        end
    endgenerate

endmodule

// File: tb/tb_nand_min.sv
// tb_nand_min: directed checks of nand_min in registered and
// combinational builds against a hand-written truth table.

module tb_nand_min;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic w1_r;
    logic z_r;
    logic w1_c;
    logic z_c;

    int checks;
    int errors;

    // {w1, z} indexed by abc
    logic [1:0] exp_tab [0:7];

    nand_min #(.REG_OUT(1'b1)) u_reg (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .w1 (w1_r),
        .z  (z_r)
    );

    nand_min #(.REG_OUT(1'b0)) u_comb (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .w1 (w1_c),
        .z  (z_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [1:0] got,
                         input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got w1z=%b expected w1z=%b", tag, got, exp);
        end
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    // Apply a vector between edges, check comb now, reg after the edge.
    task automatic step(input string tag, input logic [2:0] v);
        set_abc(v);
        #1;
        check({tag, "_comb"}, {w1_c, z_c}, exp_tab[v]);
        @(posedge clk);
        #1;
        check({tag, "_reg"}, {w1_r, z_r}, exp_tab[v]);
    endtask

    initial begin
        exp_tab[0] = 2'b10;
        exp_tab[1] = 2'b11;
        exp_tab[2] = 2'b10;
        exp_tab[3] = 2'b11;
        exp_tab[4] = 2'b10;
        exp_tab[5] = 2'b10;
        exp_tab[6] = 2'b01;
        exp_tab[7] = 2'b01;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        set_abc(3'b000);
        #1;
        check("reset_state", {w1_r, z_r}, 2'b10);

        // a=0 controls w1 even with b=X; c=0 then gives z=0.
        a = 1'b0;
        b = 1'bx;
        c = 1'b0;
        #1;
        check("xprop_a0", {w1_c, z_c}, 2'b10);

        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            step($sformatf("sweep%0d", i), 3'(i));

        // Async reset between edges.
        step("hold111", 3'b111);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {w1_r, z_r}, 2'b10);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release", {w1_r, z_r}, 2'b01);

        // Mux: a=1 selects b=0, c toggles.
        step("mux_a1_c0", 3'b100);
        step("mux_a1_c1", 3'b101);
        step("mux_a1_c0b", 3'b100);
        // Mux: a=0 selects c=1, b toggles.
        step("mux_a0_b0", 3'b001);
        step("mux_a0_b1", 3'b011);
        step("mux_a0_b0b", 3'b001);

        // Back-to-back vectors.
        step("b2b_110", 3'b110);
        step("b2b_101", 3'b101);

        // Comb sweep with reset toggling; reg build held in reset.
        for (int i = 0; i < 8; i++) begin
            rst = i[0];
            set_abc(3'(i));
            #1;
            check($sformatf("comb_rst%0d", i), {w1_c, z_c}, exp_tab[i]);
            if (rst)
                check($sformatf("reg_held%0d", i), {w1_r, z_r}, 2'b10);
            #9;
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
